mac_result_serializer: RTL

Downstream stage of the 16x16 three-tap multiply-accumulate block. It captures each completed 32-bit dot-product sum, buffers it in a small FIFO, and streams it out MSB-first as bytes over a valid/ready handshake. The byte stream feeds a UART or host-link transmitter. A sticky overflow flag reports sums lost when the buffer is full.

---
 rtl/mac_result_serializer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mac_result_serializer.sv
// -----------------------------------------------------------------------------
// mac_result_serializer
//
// Captures completed dot-product sums from the MAC stage, buffers up to
// FIFO_DEPTH of them, and streams each one out MSB-first as bytes over a
// valid/ready handshake. A sticky flag records any sum dropped because the
// buffer was full.
//
// Ports:
//   i_Clk            system clock, rising edge
//   i_Rst            synchronous active-high reset
//   i_Sum            completed sum from the MAC stage
//   i_Sum_Valid      single-cycle strobe qualifying i_Sum
//   o_Byte           current output byte
//   o_Byte_Valid     o_Byte is valid
//   i_Byte_Ready     consumer accepts o_Byte this cycle
//   o_Frame_Start    high while o_Byte is the first (MSB) byte of a word
//   o_Busy           buffer non-empty or a word is being sent
//   o_Overflow       sticky: a sum was dropped
//   i_Clear_Overflow clears o_Overflow (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module mac_result_serializer #(
    parameter int SUM_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [SUM_WIDTH-1:0] i_Sum,
    input  logic                 i_Sum_Valid,
    output logic [7:0]           o_Byte,
    output logic                 o_Byte_Valid,
    input  logic                 i_Byte_Ready,
    output logic                 o_Frame_Start,
    output logic                 o_Busy,
    output logic                 o_Overflow,
    input  logic                 i_Clear_Overflow
);

    localparam int BYTES = SUM_WIDTH / 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // Word storage; contents need no reset because the pointers/count do.
    logic [SUM_WIDTH-1:0] mem [FIFO_DEPTH];

    state_t               state_q,  state_d;
    logic [SUM_WIDTH-1:0] shift_q,  shift_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;
    logic                 valid_q,  valid_d;
    logic                 frame_q,  frame_d;
    logic                 ovf_q,    ovf_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;

    logic push;
    logic pop;
    logic xfer;
    logic fifo_empty;
    logic fifo_full;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        frame_d  = frame_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop      = 1'b0;

        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        xfer       = valid_q && i_Byte_Ready;
        // Fullness is judged on the registered count, so a pop in the same
        // cycle does not make room for an incoming sum.
        push       = i_Sum_Valid && !fifo_full;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    idx_d   = '0;
                    valid_d = 1'b1;
                    frame_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (idx_q != LAST_IDX) begin
                        shift_d = shift_q << 8;
                        idx_d   = idx_q + IDX_W'(1);
                        frame_d = 1'b0;
                    end else if (!fifo_empty) begin
                        // Back-to-back words: reload without a bubble.
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        idx_d   = '0;
                        frame_d = 1'b1;
                    end else begin
                        idx_d   = '0;
                        valid_d = 1'b0;
                        frame_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (i_Sum_Valid && fifo_full) begin
            ovf_d = 1'b1;
        end else if (i_Clear_Overflow) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            frame_q  <= 1'b0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            frame_q  <= frame_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (push && !i_Rst) begin
            mem[wr_ptr_q] <= i_Sum;
        end
    end

    assign o_Byte        = shift_q[SUM_WIDTH-1 -: 8];
    assign o_Byte_Valid  = valid_q;
    assign o_Frame_Start = frame_q;
    assign o_Overflow    = ovf_q;
    assign o_Busy        = (count_q != '0) || (state_q == S_SEND);

endmodule
